// File: rtl/din_cond_pkg.sv
// Shared types and constants for the din_conditioner input-conditioning slice.
package din_cond_pkg;

  localparam int unsigned GLITCH_W = 8;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  // Saturating increment for the aborted-transition counter.
  function automatic logic [GLITCH_W-1:0] glitch_sat_inc(input logic [GLITCH_W-1:0] v);
    return (v == {GLITCH_W{1'b1}}) ? v : v + GLITCH_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit pins; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/din_conditioner.sv
// Synchronise, debounce and edge-detect a raw pin feeding the detector's din.
// Define DIN_COND_GLITCH_CNT_EN to count aborted transitions on glitch_cnt.
module din_conditioner
  import din_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_in,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic [7:0] glitch_cnt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
`ifdef DIN_COND_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
`endif

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (sync2)
  );

  // Debounce FSM: a new level must persist DEBOUNCE_CYCLES+1 samples of sync2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef DIN_COND_GLITCH_CNT_EN
    glitch_d = glitch_q;
`endif
    case (state_q)
      IDLE_LO: begin
        if (sync2) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync2) begin
          state_d = IDLE_LO;
`ifdef DIN_COND_GLITCH_CNT_EN
          glitch_d = glitch_sat_inc(glitch_q);
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!sync2) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (sync2) begin
          state_d = IDLE_HI;
`ifdef DIN_COND_GLITCH_CNT_EN
          glitch_d = glitch_sat_inc(glitch_q);
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        dout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef DIN_COND_GLITCH_CNT_EN
      glitch_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef DIN_COND_GLITCH_CNT_EN
      glitch_q <= glitch_d;
`endif
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
`ifdef DIN_COND_GLITCH_CNT_EN
  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_din_conditioner.sv
// Bench for din_conditioner: N=4 and N=1 instances against a run-length scoreboard model.
module tb_din_conditioner;

`ifdef DIN_COND_GLITCH_CNT_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       raw_in = 1'b0;
  logic       dout4, rise4, fall4;
  logic [7:0] glitch4;
  logic       dout1, rise1, fall1;
  logic [7:0] glitch1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic h1;
    logic h2;
    logic dout;
    logic rise;
    logic fall;
    int   run;
    int   glitch;
  } model_t;

  model_t m4 = '0;
  model_t m1 = '0;
  logic [10:0] q4[$];
  logic [10:0] q1[$];

  din_conditioner #(.DEBOUNCE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .dout(dout4), .rise(rise4), .fall(fall4), .glitch_cnt(glitch4)
  );

  din_conditioner #(.DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .dout(dout1), .rise(rise1), .fall(fall1), .glitch_cnt(glitch1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: dout flips once sync2 has differed from it for n+1 consecutive samples.
  function automatic model_t mstep(model_t m, logic r, logic raw, int n);
    model_t o;
    logic   s;
    o      = m;
    o.rise = 1'b0;
    o.fall = 1'b0;
    if (!r) begin
      o = '0;
      return o;
    end
    s    = m.h2;
    o.h2 = m.h1;
    o.h1 = raw;
    if (s != m.dout) begin
      o.run = m.run + 1;
      if (o.run == n + 1) begin
        o.dout = s;
        o.rise = s;
        o.fall = !s;
        o.run  = 0;
      end
    end else begin
      if (m.run > 0 && m.glitch < 255) o.glitch = m.glitch + 1;
      o.run = 0;
    end
    return o;
  endfunction

  function automatic logic [10:0] pack_exp(model_t m);
    logic [7:0] g;
    g = GLITCH_EN ? 8'(m.glitch) : 8'd0;
    return {m.dout, m.rise, m.fall, g};
  endfunction

  always @(posedge clk) begin
    model_t n4, n1;
    n4 = mstep(m4, rst, raw_in, 4);
    n1 = mstep(m1, rst, raw_in, 1);
    m4 <= n4;
    m1 <= n1;
    q4.push_back(pack_exp(n4));
    q1.push_back(pack_exp(n1));
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      check_eq("n4_dout",   32'(dout4),   32'(e[10]));
      check_eq("n4_rise",   32'(rise4),   32'(e[9]));
      check_eq("n4_fall",   32'(fall4),   32'(e[8]));
      check_eq("n4_glitch", 32'(glitch4), 32'(e[7:0]));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check_eq("n1_dout",   32'(dout1),   32'(e[10]));
      check_eq("n1_rise",   32'(rise1),   32'(e[9]));
      check_eq("n1_fall",   32'(fall1),   32'(e[8]));
      check_eq("n1_glitch", 32'(glitch1), 32'(e[7:0]));
    end
    check_eq("n4_rise_fall_excl", 32'(rise4 & fall4), 32'd0);
  end

  task automatic drive(input logic r, input logic raw, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst    = r;
      raw_in = raw;
    end
  endtask

  initial begin
    // Reset, then clean rise and clean fall.
    drive(1'b0, 1'b0, 3);
    drive(1'b1, 1'b1, 12);
    @(negedge clk);
    #1;
    check_eq("clean_rise_level", 32'(dout4), 32'd1);
    drive(1'b1, 1'b0, 12);
    @(negedge clk);
    #1;
    check_eq("clean_fall_level", 32'(dout4), 32'd0);
    check_eq("pre_bounce_glitch", 32'(glitch4), 32'd0);

    // Bounce rejection.
    drive(1'b1, 1'b1, 2);
    drive(1'b1, 1'b0, 2);
    drive(1'b1, 1'b1, 2);
    drive(1'b1, 1'b0, 20);
    @(negedge clk);
    #1;
    check_eq("bounce_dout", 32'(dout4), 32'd0);
    check_eq("bounce_glitch", 32'(glitch4), GLITCH_EN ? 32'd2 : 32'd0);

    // Reset mid-debounce with raw held high.
    drive(1'b1, 1'b1, 4);
    drive(1'b0, 1'b1, 1);
    drive(1'b1, 1'b1, 12);
    @(negedge clk);
    #1;
    check_eq("post_reset_rise", 32'(dout4), 32'd1);

    // N=1 boundary: 1-cycle low pulse rejected, 2-cycle low pulse falls.
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 6);
    check_eq("n1_short_low_rejected", 32'(dout1), 32'd1);
    drive(1'b1, 1'b0, 2);
    drive(1'b1, 1'b1, 6);

    // Glitch saturation on the N=4 instance.
    drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 4);
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 1'b1, 2);
      drive(1'b1, 1'b0, 2);
    end
    drive(1'b1, 1'b0, 10);
    @(negedge clk);
    #1;
    check_eq("sat_glitch", 32'(glitch4), GLITCH_EN ? 32'd255 : 32'd0);
    check_eq("sat_dout", 32'(dout4), 32'd0);

    drive(1'b1, 1'b0, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
